seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of scanned digits (legal range 1..8).
REQ-002 Parameter INVERT, default 0; when 1, segment inputs are active-low and are complemented before decoding.
REQ-003 Parameter STABLE_CYCLES, default 4, consecutive identical samples required to commit a digit (legal range 1..255).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seg_in  input  7  segment lines, bit0=a .. bit6=g.
REQ-007 digit_sel  input  NUM_DIGITS  one-hot digit strobe; bit i high means seg_in belongs to digit i.
REQ-008 avs_address  input  2  Avalon-MM slave word address.
REQ-009 avs_read  input  1  Avalon-MM read strobe.
REQ-010 avs_readdata  output  32  Avalon-MM read data, fixed read latency 1.

Function
REQ-011 Each cycle, pattern p = seg_in, or ~seg_in when INVERT=1.
REQ-012 Decode p: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F; 00 -> blank; any other value -> invalid.
REQ-013 Sample is usable only if digit_sel has exactly one bit set; zero or multiple bits set: sample discarded and the stability counter cleared to 0.
REQ-014 Stability counter: increments, saturating, when the usable sample has the same digit_sel and p as the previous cycle's sample; otherwise it loads 1 (usable) or 0 (unusable).
REQ-015 Commit: on the edge where the counter's new value equals STABLE_CYCLES, digit i registers update (nibble, valid, blank); no further commit occurs until the counter reloads.
REQ-016 Commit of a decoded value: nibble=value, valid=1, blank=0; of blank: nibble=0, valid=0, blank=1; of invalid: nibble unchanged, valid=0, blank=0.
REQ-017 change[i] sets on a commit whose {nibble,valid,blank} differs from the stored value.
REQ-018 Register map: addr0 = digit nibbles, digit i in bits 4i+3:4i; addr1 = valid mask bits 7:0, blank mask bits 15:8; addr2 = change flags bits 7:0; addr3 = error counter bits 15:0; unused bits read 0.
REQ-019 avs_readdata is registered: value for the address sampled with avs_read at edge k is presented after edge k and holds until the next read.
REQ-020 Reading addr2 clears the flags read; a change setting in the same cycle wins (that bit remains 1).
REQ-021 Error counter increments by 1 on every invalid commit, saturating at 0xFFFF.
REQ-022 No wait states; avs_read at any address is accepted every cycle.

Reset
REQ-023 reset high at a clock edge clears all nibbles, valid, blank and change bits, the error counter, the stability counter, the previous-sample registers and avs_readdata to 0.
REQ-024 reset asserted mid-accumulation discards the partial count; the next commit requires a full STABLE_CYCLES samples after reset deasserts.

Configuration
REQ-025 Macro SEG7_ERRCNT_EN: when defined, the error counter of REQ-021 is implemented; when undefined, no counter logic exists and addr3 reads 0x00000000.

Verification
REQ-026 INVERT=0, STABLE_CYCLES=4: digit_sel=000001, seg_in=0x5B for 4 cycles -> addr0=0x00000002, addr1=0x00000001, addr2=0x00000001.
REQ-027 Same digit, seg_in=0x5B for 3 cycles then 0x4F for 4 cycles -> single commit of 3; addr0 bits 3:0 = 3, no commit of 2.
REQ-028 digit_sel=000011 with seg_in=0x06 for 10 cycles -> no commit; addr0=0, addr1=0, addr2=0.
REQ-029 SEG7_ERRCNT_EN defined, digit 2, seg_in=0x55 for 4 cycles -> addr1 bit2=0, addr3=0x00000001; macro undefined -> addr3=0.
REQ-030 Read addr2 on the same edge digit 1 commits a new value -> readdata shows prior flags; next read of addr2 shows bit1=1.
REQ-031 INVERT=1, seg_in=~0x71 (0x0E) for 4 cycles on digit 5 -> addr0 bits 23:20 = 0xF; reset pulse then -> all reads 0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: debounces strobed segment patterns per digit and
// exposes decoded digits over Avalon-MM. Optional error counter: SEG7_ERRCNT_EN.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned INVERT        = 0,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic [NUM_DIGITS-1:0] digit_sel,
    input  logic [1:0]            avs_address,
    input  logic                  avs_read,
    output logic [31:0]           avs_readdata
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [SEG_W-1:0]      pat;
    logic                  usable;
    logic                  same;
    logic                  commit;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [NUM_DIGITS-1:0] prev_sel_q;
    logic [SEG_W-1:0]      prev_pat_q;

    logic [NIB_W-1:0]      dec_val;
    logic                  is_hex;
    logic                  is_blank;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] nibble_q, nibble_nxt;
    logic [NUM_DIGITS-1:0] valid_q, valid_nxt;
    logic [NUM_DIGITS-1:0] blank_q, blank_nxt;
    logic [NUM_DIGITS-1:0] change_q, change_nxt;
    logic [NIB_W-1:0]      nib_new;
    logic                  rd_clr;
    logic [31:0]           rd_word;

    // Sample qualification and stability run length
    always_comb begin
        pat     = (INVERT != 0) ? ~seg_in : seg_in;
        usable  = (digit_sel != '0) && ((digit_sel & (digit_sel - SEL_ONE)) == '0);
        same    = usable && (digit_sel == prev_sel_q) && (pat == prev_pat_q);
        cnt_nxt = usable ? CNT_W'(1) : '0;
        if (same) begin
            cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        // A run saturated exactly at STABLE must not re-commit every cycle
        commit  = usable && (cnt_nxt == STABLE) && !(same && (cnt_q == STABLE));
    end

    // Pattern decode
    always_comb begin
        dec_val  = '0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (pat)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h67: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default: is_hex = 1'b0;
        endcase
    end

    // Digit register update; a change flag set this cycle beats a read-clear
    always_comb begin
        rd_clr     = avs_read && (avs_address == 2'd2);
        nibble_nxt = nibble_q;
        valid_nxt  = valid_q;
        blank_nxt  = blank_q;
        change_nxt = rd_clr ? '0 : change_q;
        nib_new    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (commit && digit_sel[i]) begin
                nib_new       = is_hex ? dec_val : (is_blank ? 4'h0 : nibble_q[i]);
                nibble_nxt[i] = nib_new;
                valid_nxt[i]  = is_hex;
                blank_nxt[i]  = is_blank;
                if ({nib_new, is_hex, is_blank} != {nibble_q[i], valid_q[i], blank_q[i]}) begin
                    change_nxt[i] = 1'b1;
                end
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    logic [15:0] err_q, err_nxt;

    always_comb begin
        err_nxt = err_q;
        if (commit && !is_hex && !is_blank && (err_q != 16'hFFFF)) begin
            err_nxt = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= err_nxt;
    end
`endif

    // Read data mux
    always_comb begin
        rd_word = '0;
        case (avs_address)
            2'd0: rd_word = 32'(nibble_q);
            2'd1: rd_word = {16'h0000, 8'(blank_q), 8'(valid_q)};
            2'd2: rd_word = 32'(change_q);
`ifdef SEG7_ERRCNT_EN
            2'd3: rd_word = {16'h0000, err_q};
`else
            2'd3: rd_word = '0;
`endif
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            prev_sel_q   <= '0;
            prev_pat_q   <= '0;
            nibble_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            change_q     <= '0;
            avs_readdata <= '0;
        end else begin
            cnt_q      <= cnt_nxt;
            prev_sel_q <= digit_sel;
            prev_pat_q <= pat;
            nibble_q   <= nibble_nxt;
            valid_q    <= valid_nxt;
            blank_q    <= blank_nxt;
            change_q   <= change_nxt;
            if (avs_read) avs_readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed cases plus random scan
// traffic checked against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 6;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg_in;
    logic [ND-1:0] digit_sel;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic [31:0]   avs_readdata;

    logic [6:0]    i_seg_in;
    logic [ND-1:0] i_digit_sel;
    logic [1:0]    i_avs_address;
    logic          i_avs_read;
    logic [31:0]   i_avs_readdata;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .INVERT(0), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel),
        .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata)
    );

    seg7_scan_decoder #(.NUM_DIGITS(ND), .INVERT(1), .STABLE_CYCLES(SC)) dut_inv (
        .clk(clk), .reset(reset), .seg_in(i_seg_in), .digit_sel(i_digit_sel),
        .avs_address(i_avs_address), .avs_read(i_avs_read), .avs_readdata(i_avs_readdata)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] hex_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [3:0]    m_nib [ND];
    bit            m_val [ND];
    bit            m_blk [ND];
    bit            m_chg [ND];
    int            m_err;
    logic [31:0]   m_rdata;
    bit            prev_ok;
    logic [ND-1:0] prev_sel;
    logic [6:0]    prev_pat;
    int            run;

    function automatic int decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++) if (hex_pat[k] == p) return k;
        if (p == 7'h00) return -1;
        return -2;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < ND; i++) begin
            if (a == 0) w = w | (32'(m_nib[i]) << (4 * i));
            if (a == 1) begin
                w[i]     = m_val[i];
                w[8 + i] = m_blk[i];
            end
            if (a == 2) w[i] = m_chg[i];
        end
`ifdef SEG7_ERRCNT_EN
        if (a == 3) w = 32'(m_err);
`endif
        return w;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ND; i++) begin
            m_nib[i] = '0; m_val[i] = 0; m_blk[i] = 0; m_chg[i] = 0;
        end
        m_err = 0; m_rdata = '0; prev_ok = 0; prev_sel = '0; prev_pat = '0; run = 0;
    endfunction

    // One clock edge of the specified behaviour
    function automatic void model_edge(input logic [ND-1:0] sel, input logic [6:0] pat,
                                       input bit rd, input int addr);
        bit         usable;
        int         d, k;
        logic [3:0] nn;
        bit         nv, nb;
        if (rd) m_rdata = model_read(addr);
        usable = ($countones(sel) == 1);
        if (usable && prev_ok && sel == prev_sel && pat == prev_pat) run = run + 1;
        else run = usable ? 1 : 0;
        prev_ok = usable; prev_sel = sel; prev_pat = pat;
        if (rd && addr == 2) for (int i = 0; i < ND; i++) m_chg[i] = 0;
        if (usable && run == SC) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (sel[i]) d = i;
            k = decode(pat);
            if (k >= 0)       begin nn = 4'(k);    nv = 1; nb = 0; end
            else if (k == -1) begin nn = 4'h0;     nv = 0; nb = 1; end
            else              begin nn = m_nib[d]; nv = 0; nb = 0; end
            if (nn != m_nib[d] || nv != m_val[d] || nb != m_blk[d]) m_chg[d] = 1;
            if (k == -2 && m_err < 65535) m_err = m_err + 1;
            m_nib[d] = nn; m_val[d] = nv; m_blk[d] = nb;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [ND-1:0] sel, input logic [6:0] seg, input bit rd, input int addr);
        digit_sel = sel; seg_in = seg; avs_read = rd; avs_address = 2'(addr);
        @(posedge clk);
        model_edge(sel, seg, rd, addr);
        #1;
        check($sformatf("rdata_a%0d", addr), avs_readdata, m_rdata);
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
        repeat (n) step(sel, seg, 0, 0);
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        step('0, 7'h00, 1, addr);
        check($sformatf("const_a%0d", addr), avs_readdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; digit_sel = '0; seg_in = '0; avs_read = 1'b0; avs_address = '0;
        i_digit_sel = '0; i_seg_in = '0; i_avs_read = 1'b0; i_avs_address = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check("reset_rdata", avs_readdata, 32'h0);
        check("reset_inv_rdata", i_avs_readdata, 32'h0);
    endtask

    task automatic inv_rd(input int addr, input logic [31:0] exp);
        i_digit_sel = '0; i_avs_read = 1'b1; i_avs_address = 2'(addr);
        @(posedge clk);
        #1;
        i_avs_read = 1'b0;
        check($sformatf("inv_a%0d", addr), i_avs_readdata, exp);
    endtask

    initial begin
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        int            len, c, a, b;
        logic [31:0]   exp_err;

`ifdef SEG7_ERRCNT_EN
        exp_err = 32'h1;
`else
        exp_err = 32'h0;
`endif

        do_reset();
        for (int i = 0; i < 4; i++) rd(i, 32'h0);

        // Basic commit after four stable samples
        hold(6'b000001, 7'h5B, 4);
        rd(0, 32'h0000_0002);
        rd(1, 32'h0000_0001);
        rd(2, 32'h0000_0001);
        rd(2, 32'h0000_0000);

        // Interrupted run: only the later value commits
        do_reset();
        hold(6'b000001, 7'h5B, 3);
        hold(6'b000001, 7'h4F, 4);
        rd(0, 32'h0000_0003);
        rd(2, 32'h0000_0001);

        // Multi-hot strobe never commits
        do_reset();
        hold(6'b000011, 7'h06, 10);
        rd(0, 32'h0); rd(1, 32'h0); rd(2, 32'h0);

        // Invalid pattern and error counter
        do_reset();
        hold(6'b000100, 7'h55, 4);
        rd(1, 32'h0);
        rd(3, exp_err);
        rd(2, 32'h0);

        // Read-clear racing a new commit
        do_reset();
        hold(6'b000010, 7'h06, 4);
        rd(2, 32'h0000_0002);
        hold(6'b000010, 7'h5B, 3);
        step(6'b000010, 7'h5B, 1, 2);
        check("race_prior", avs_readdata, 32'h0);
        rd(2, 32'h0000_0002);
        rd(0, 32'h0000_0020);

        // Blank: three samples are one short, four commit
        do_reset();
        hold(6'b001000, 7'h00, 3);
        rd(1, 32'h0);
        hold(6'b001000, 7'h00, 4);
        rd(1, 32'h0000_0800);

        // Long hold past counter saturation commits exactly once
        do_reset();
        hold(6'b010000, 7'h06, 5);
        step(6'b010000, 7'h06, 1, 2);
        check("sat_first", avs_readdata, 32'h0000_0010);
        hold(6'b010000, 7'h55, 300);
        rd(1, 32'h0);
        rd(3, exp_err);
        rd(2, 32'h0000_0010);
        rd(0, 32'h0001_0000);

        // Reset mid-accumulation discards the partial run
        do_reset();
        hold(6'b000001, 7'h06, 3);
        do_reset();
        hold(6'b000001, 7'h06, 3);
        rd(1, 32'h0);
        hold(6'b000001, 7'h06, 4);
        rd(1, 32'h0000_0001);

        // Random scan traffic against the model
        do_reset();
        for (int r = 0; r < 70; r++) begin
            c = $urandom_range(0, 9);
            if (c == 0) sel = '0;
            else if (c == 1) begin
                a = $urandom_range(0, ND - 1);
                b = (a + $urandom_range(1, ND - 1)) % ND;
                sel = (ND'(1) << a) | (ND'(1) << b);
            end else sel = ND'(1) << $urandom_range(0, ND - 1);
            c = $urandom_range(0, 9);
            if (c < 7)       seg = hex_pat[$urandom_range(0, 15)];
            else if (c == 7) seg = 7'h00;
            else             seg = 7'($urandom);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++)
                step(sel, seg, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end
        for (int i = 0; i < 4; i++) step('0, 7'h00, 1, i);

        // Active-low segment instance
        do_reset();
        i_digit_sel = 6'b100000; i_seg_in = 7'h0E;
        repeat (4) @(posedge clk);
        #1;
        inv_rd(0, 32'h00F0_0000);
        inv_rd(1, 32'h0000_0020);
        do_reset();
        for (int i = 0; i < 4; i++) inv_rd(i, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
